// File: rtl/keypad_pkg.sv
// Shared types and constants for the matrix keypad scanner.
package keypad_pkg;

    localparam int unsigned COLS  = 4;
    localparam int unsigned ROWS  = 4;
    localparam int unsigned COL_W = 2;
    localparam int unsigned ROW_W = 2;
    localparam int unsigned KEY_W = ROW_W + COL_W;

    localparam logic [COLS-1:0] COL_IDLE = 4'b1110;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } scan_state_t;

    // Active-low one-hot column drive for a column index.
    function automatic logic [COLS-1:0] col_drive(input logic [COL_W-1:0] idx);
        return ~(COLS'(1) << idx);
    endfunction

    // True when exactly one row line is pulled low.
    function automatic logic single_low(input logic [ROWS-1:0] rows);
        return $countones(~rows) == 1;
    endfunction

    // Index of the lowest row line that is pulled low.
    function automatic logic [ROW_W-1:0] low_row(input logic [ROWS-1:0] rows);
        logic [ROW_W-1:0] idx;
        idx = '0;
        for (int i = int'(ROWS) - 1; i >= 0; i--) begin
            if (!rows[i]) idx = ROW_W'(i);
        end
        return idx;
    endfunction

    // Row pattern seen when only the given row is pulled low.
    function automatic logic [ROWS-1:0] row_pattern(input logic [ROW_W-1:0] idx);
        logic [ROWS-1:0] pat;
        pat      = '1;
        pat[idx] = 1'b0;
        return pat;
    endfunction

endpackage

// File: rtl/keypad_scan_tick_gen.sv
// Free-running divider producing a one-clock tick every SCAN_DIV cycles.
module scan_tick_gen #(
    parameter int unsigned SCAN_DIV = 50_000
) (
    input  logic clk,
    input  logic reset,
    output logic tick_c
);

    localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [DIV_W-1:0] div_cnt;

    assign tick_c = (div_cnt == DIV_W'(SCAN_DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
        end else if (tick_c) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner with debounce and a one-entry valid/ack holding register.
// Optional auto-repeat while a key is held: define KEYPAD_REPEAT_EN.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV       = 50_000,
    parameter int unsigned DEBOUNCE_SCANS = 4,
    parameter int unsigned REPEAT_SCANS   = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [ROWS-1:0]  row_in,
    output logic [COLS-1:0]  col_out,
    output logic [KEY_W-1:0] key_code,
    output logic             key_valid,
    input  logic             key_ack,
    output logic             overrun
);

    localparam int unsigned DEB_W = $clog2(DEBOUNCE_SCANS + 1);
    // Press is accepted on the tick that makes DEBOUNCE_SCANS matching samples in total.
    localparam logic [DEB_W-1:0] DEB_EMIT = DEB_W'((DEBOUNCE_SCANS > 1) ? DEBOUNCE_SCANS - 2 : 0);
    localparam logic [DEB_W-1:0] DEB_DONE = DEB_W'((DEBOUNCE_SCANS > 0) ? DEBOUNCE_SCANS - 1 : 0);

    logic              tick;
    logic [ROWS-1:0]   row_meta;
    logic [ROWS-1:0]   row_s;
    scan_state_t       state;
    scan_state_t       state_nxt;
    logic [COL_W-1:0]  col_idx;
    logic [COL_W-1:0]  col_idx_nxt;
    logic [ROW_W-1:0]  cand_row;
    logic [ROW_W-1:0]  cand_row_nxt;
    logic [DEB_W-1:0]  deb_cnt;
    logic [DEB_W-1:0]  deb_cnt_nxt;
    logic              emit_c;
    logic [KEY_W-1:0]  emit_code_c;

`ifdef KEYPAD_REPEAT_EN
    localparam int unsigned REP_W = $clog2(REPEAT_SCANS + 1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_SCANS - 1);

    logic [REP_W-1:0] rep_cnt;
    logic [REP_W-1:0] rep_cnt_nxt;
`else
    // Keeps the repeat parameter referenced when auto-repeat is compiled out.
    logic unused_repeat;
    assign unused_repeat = (REPEAT_SCANS == 0);
`endif

    scan_tick_gen #(
        .SCAN_DIV (SCAN_DIV)
    ) u_tick (
        .clk    (clk),
        .reset  (reset),
        .tick_c (tick)
    );

    // Two-flop synchroniser for the asynchronous row lines (idle high).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_meta <= '1;
            row_s    <= '1;
        end else begin
            row_meta <= row_in;
            row_s    <= row_meta;
        end
    end

    // State and scan registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= SCAN;
            col_idx  <= '0;
            cand_row <= '0;
            deb_cnt  <= '0;
            col_out  <= COL_IDLE;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt  <= '0;
`endif
        end else begin
            state    <= state_nxt;
            col_idx  <= col_idx_nxt;
            cand_row <= cand_row_nxt;
            deb_cnt  <= deb_cnt_nxt;
            col_out  <= col_drive(col_idx_nxt);
`ifdef KEYPAD_REPEAT_EN
            rep_cnt  <= rep_cnt_nxt;
`endif
        end
    end

    assign emit_code_c = {cand_row, col_idx};

    // Next-state logic; every decision is taken on a scan tick only.
    always_comb begin
        state_nxt    = state;
        col_idx_nxt  = col_idx;
        cand_row_nxt = cand_row;
        deb_cnt_nxt  = deb_cnt;
        emit_c       = 1'b0;
`ifdef KEYPAD_REPEAT_EN
        rep_cnt_nxt  = rep_cnt;
`endif
        if (tick) begin
            unique case (state)
                SCAN: begin
                    if (single_low(row_s)) begin
                        cand_row_nxt = low_row(row_s);
                        deb_cnt_nxt  = '0;
                        state_nxt    = DEBOUNCE;
                    end else begin
                        col_idx_nxt = col_idx + COL_W'(1);
                    end
                end
                DEBOUNCE: begin
                    if (row_s == row_pattern(cand_row)) begin
                        deb_cnt_nxt = deb_cnt + DEB_W'(1);
                        if (deb_cnt == DEB_EMIT) begin
                            emit_c    = 1'b1;
                            state_nxt = HELD;
`ifdef KEYPAD_REPEAT_EN
                            rep_cnt_nxt = '0;
`endif
                        end
                    end else begin
                        state_nxt   = SCAN;
                        col_idx_nxt = col_idx + COL_W'(1);
                    end
                end
                HELD: begin
                    if (row_s == '1) begin
                        deb_cnt_nxt = '0;
                        state_nxt   = RELEASE;
`ifdef KEYPAD_REPEAT_EN
                        rep_cnt_nxt = '0;
                    end else if (rep_cnt == REP_LAST) begin
                        emit_c      = 1'b1;
                        rep_cnt_nxt = '0;
                    end else begin
                        rep_cnt_nxt = rep_cnt + REP_W'(1);
`endif
                    end
                end
                RELEASE: begin
                    if (row_s == '1) begin
                        if (deb_cnt == DEB_DONE) begin
                            state_nxt   = SCAN;
                            col_idx_nxt = col_idx + COL_W'(1);
                        end else begin
                            deb_cnt_nxt = deb_cnt + DEB_W'(1);
                        end
                    end else begin
                        state_nxt = HELD;
                    end
                end
                default: state_nxt = SCAN;
            endcase
        end
    end

    // Holding register: a new key loads when empty or accepted in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_code  <= '0;
            key_valid <= 1'b0;
            overrun   <= 1'b0;
        end else if (emit_c) begin
            if (!key_valid || key_ack) begin
                key_code  <= emit_code_c;
                key_valid <= 1'b1;
                if (key_valid && key_ack) overrun <= 1'b0;
            end else begin
                overrun <= 1'b1;
            end
        end else if (key_valid && key_ack) begin
            key_valid <= 1'b0;
            overrun   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_keypad_scan.sv
// Self-checking bench for keypad_scan with a tick-level keypad model; honours KEYPAD_REPEAT_EN.
module tb_keypad_scan;

    localparam int SDIV = 4;
    localparam int DEB  = 3;
    localparam int REP  = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ack = 1'b0;
    logic       overrun;

    logic [15:0] key_held = '0;
    logic        force_en = 1'b0;
    logic [3:0]  force_rows = 4'hF;
    logic [3:0]  matrix_rows;

    int total = 0;
    int bad = 0;

    keypad_scan #(
        .SCAN_DIV       (SDIV),
        .DEBOUNCE_SCANS (DEB),
        .REPEAT_SCANS   (REP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .row_in    (row_in),
        .col_out   (col_out),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_ack   (key_ack),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    // Physical matrix: a held key (index = row*4+col) pulls its row low while its column is driven.
    always_comb begin
        matrix_rows = 4'hF;
        for (int i = 0; i < 16; i++) begin
            if (key_held[i] && !col_out[i % 4]) matrix_rows[i / 4] = 1'b0;
        end
        row_in = force_en ? force_rows : matrix_rows;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: per-tick press/release tracking plus the holding-register rules.
    int         m_div, m_col, m_cand, m_run, m_rel, m_rep, m_emits;
    bit         m_pressed, m_valid, m_ovr, m_tick, m_em;
    logic [3:0] m_code, m_s1, m_s2, m_r, m_pat, m_ecode;

    always @(posedge clk) begin
        if (reset) begin
            m_div = 0; m_col = 0; m_cand = 0; m_run = 0; m_rel = 0; m_rep = 0;
            m_pressed = 0; m_valid = 0; m_ovr = 0; m_code = 4'h0;
            m_s1 = 4'hF; m_s2 = 4'hF;
        end else begin
            m_tick = (m_div == SDIV - 1);
            m_div  = m_tick ? 0 : m_div + 1;
            m_em   = 0;
            m_r    = m_s2;
            if (m_tick) begin
                if (!m_pressed) begin
                    if (m_run == 0) begin
                        if ($countones(~m_r) == 1) begin
                            for (int i = 3; i >= 0; i--) if (!m_r[i]) m_cand = i;
                            m_run = 1;
                        end else begin
                            m_col = (m_col + 1) % 4;
                        end
                    end else begin
                        m_pat = 4'hF;
                        m_pat[m_cand] = 1'b0;
                        if (m_r == m_pat) begin
                            m_run++;
                            if (m_run == DEB) begin
                                m_em = 1; m_ecode = 4'(m_cand * 4 + m_col);
                                m_pressed = 1; m_rel = 0; m_rep = 0;
                            end
                        end else begin
                            m_run = 0;
                            m_col = (m_col + 1) % 4;
                        end
                    end
                end else if (m_r == 4'hF) begin
                    m_rel++;
                    m_rep = 0;
                    if (m_rel == DEB + 1) begin
                        m_pressed = 0; m_run = 0;
                        m_col = (m_col + 1) % 4;
                    end
                end else begin
`ifdef KEYPAD_REPEAT_EN
                    if (m_rel == 0) begin
                        m_rep++;
                        if (m_rep == REP) begin
                            m_em = 1; m_ecode = 4'(m_cand * 4 + m_col); m_rep = 0;
                        end
                    end
`endif
                    m_rel = 0;
                end
            end
            if (m_em) begin
                m_emits++;
                if (!m_valid || key_ack) begin
                    if (m_valid && key_ack) m_ovr = 0;
                    m_code = m_ecode; m_valid = 1;
                end else begin
                    m_ovr = 1;
                end
            end else if (m_valid && key_ack) begin
                m_valid = 0; m_ovr = 0;
            end
            m_s2 = m_s1;
            m_s1 = row_in;
        end
    end

    // Cycle-by-cycle comparison against the model.
    logic [3:0] exp_col;
    always @(negedge clk) begin
        if (!reset) begin
            exp_col = ~(4'b0001 << m_col);
            check("col_out", 32'(col_out), 32'(exp_col));
            check("key_valid", 32'(key_valid), 32'(m_valid));
            check("overrun", 32'(overrun), 32'(m_ovr));
            if (m_valid) check("key_code", 32'(key_code), 32'(m_code));
        end
    end

    task automatic wait_ticks(input int n);
        repeat (n * SDIV) @(negedge clk);
    endtask

    task automatic wait_valid(input string nm, input int limit);
        int k = 0;
        while (!key_valid && k < limit) begin
            @(negedge clk);
            k++;
        end
        total++;
        if (!key_valid) begin
            bad++;
            $display("FAIL %s timeout waiting for key_valid", nm);
        end
    endtask

    task automatic wait_overrun(input string nm, input int limit);
        int k = 0;
        while (!overrun && k < limit) begin
            @(negedge clk);
            k++;
        end
        total++;
        if (!overrun) begin
            bad++;
            $display("FAIL %s timeout waiting for overrun", nm);
        end
    endtask

    task automatic do_ack();
        key_ack = 1'b1;
        @(negedge clk);
        key_ack = 1'b0;
    endtask

    logic [3:0] rot [5];
    logic [3:0] c0;
    int         events;
    int         k;

    initial begin
        rot[0] = 4'b1110; rot[1] = 4'b1101; rot[2] = 4'b1011; rot[3] = 4'b0111; rot[4] = 4'b1110;
        repeat (3) @(negedge clk);
        check("rst_col", 32'(col_out), 32'h0000000E);
        check("rst_valid", 32'(key_valid), 32'h0);
        check("rst_ovr", 32'(overrun), 32'h0);
        check("rst_code", 32'(key_code), 32'h0);
        reset = 1'b0;

        // Column rotation with an idle keypad.
        check("rot0", 32'(col_out), 32'(rot[0]));
        for (int i = 1; i < 5; i++) begin
            repeat (SDIV) @(negedge clk);
            check("rot", 32'(col_out), 32'(rot[i]));
        end

        // Reset in the middle of a dwell.
        repeat (SDIV + 2) @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_col", 32'(col_out), 32'h0000000E);
        check("midrst_valid", 32'(key_valid), 32'h0);
        check("midrst_ovr", 32'(overrun), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Clean press: row 2, column 1.
        key_held[9] = 1'b1;
        wait_valid("clean", 200);
        check("clean_code", 32'(key_code), 32'h9);
        do_ack();
        check("clean_ack", 32'(key_valid), 32'h0);
        wait_ticks(6);
        check("clean_single", 32'(key_valid), 32'h0);
        key_held = '0;
        wait_ticks(8);

        // One-tick glitches on row 0 while column 3 is driven.
        for (int g = 0; g < 3; g++) begin
            k = 0;
            while (m_col != 3 && k < 100) begin
                @(negedge clk);
                k++;
            end
            force_rows = 4'b1110;
            force_en = 1'b1;
            repeat (SDIV) @(negedge clk);
            force_en = 1'b0;
            force_rows = 4'hF;
            wait_ticks(3);
        end
        check("bounce_novalid", 32'(key_valid), 32'h0);

        // Release bounce: brief re-press during release must not re-emit.
        key_held[6] = 1'b1;
        wait_valid("relb", 200);
        check("relb_code", 32'(key_code), 32'h6);
        do_ack();
        key_held = '0;
        wait_ticks(2);
        key_held[6] = 1'b1;
        wait_ticks(2);
        key_held = '0;
        wait_ticks(10);
        check("relb_novalid", 32'(key_valid), 32'h0);
        check("relb_ovr", 32'(overrun), 32'h0);

        // Overrun: second key without ack is dropped.
        key_held[0] = 1'b1;
        wait_valid("ovr_first", 200);
        check("ovr_code0", 32'(key_code), 32'h0);
        key_held = '0;
        wait_ticks(8);
        key_held[5] = 1'b1;
        wait_overrun("ovr", 200);
        check("ovr_keep_code", 32'(key_code), 32'h0);
        check("ovr_valid", 32'(key_valid), 32'h1);
        check("ovr_flag", 32'(overrun), 32'h1);
        key_held = '0;
        wait_ticks(8);
        do_ack();
        check("ovr_ack_valid", 32'(key_valid), 32'h0);
        check("ovr_ack_flag", 32'(overrun), 32'h0);

        // Ack on the emit cycle loads the new code.
        key_held[0] = 1'b1;
        wait_valid("ackemit_first", 200);
        key_held = '0;
        wait_ticks(8);
        key_held[15] = 1'b1;
        k = 0;
        while (!(!m_pressed && m_run == DEB - 1) && k < 200) begin
            @(negedge clk);
            k++;
        end
        k = 0;
        while (m_div != SDIV - 1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        do_ack();
        check("ackemit_valid", 32'(key_valid), 32'h1);
        check("ackemit_code", 32'(key_code), 32'hF);
        check("ackemit_ovr", 32'(overrun), 32'h0);
        key_held = '0;
        wait_ticks(8);
        do_ack();
        check("ackemit_clear", 32'(key_valid), 32'h0);

        // Ghost: two rows low together never registers and the scan keeps moving.
        force_rows = 4'b1100;
        force_en = 1'b1;
        wait_ticks(1);
        for (int g = 0; g < 2; g++) begin
            k = 0;
            while (m_div != 0 && k < 20) begin
                @(negedge clk);
                k++;
            end
            c0 = col_out;
            repeat (SDIV) @(negedge clk);
            check("ghost_rotate", 32'(col_out), 32'({c0[2:0], c0[3]}));
        end
        force_en = 1'b0;
        force_rows = 4'hF;
        check("ghost_novalid", 32'(key_valid), 32'h0);
        wait_ticks(4);

        // Hold key 0xA, acking every event.
        key_held[10] = 1'b1;
        wait_valid("rep", 200);
        check("rep_code", 32'(key_code), 32'hA);
        events = 0;
        for (int c = 0; c < 36 * SDIV; c++) begin
            if (c == 26 * SDIV) key_held = '0;
            if (key_valid && !key_ack) begin
                events++;
                key_ack = 1'b1;
            end else begin
                key_ack = 1'b0;
            end
            @(negedge clk);
        end
        key_ack = 1'b0;
`ifdef KEYPAD_REPEAT_EN
        check("rep_events", 32'(events), 32'd4);
`else
        check("rep_events", 32'(events), 32'd1);
`endif

        // Reset while a key is held with overrun set; the key is debounced afresh.
        key_held[0] = 1'b1;
        wait_valid("rstp_first", 200);
        key_held = '0;
        wait_ticks(8);
        key_held[5] = 1'b1;
        wait_overrun("rstp", 200);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rstp_col", 32'(col_out), 32'h0000000E);
        check("rstp_valid", 32'(key_valid), 32'h0);
        check("rstp_ovr", 32'(overrun), 32'h0);
        check("rstp_code", 32'(key_code), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        wait_valid("rstp_again", 200);
        check("rstp_code5", 32'(key_code), 32'h5);
        key_held = '0;
        wait_ticks(8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
